// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational read ports, two write
// ports (port 1 / LSU has priority over port 0 / ALU) with write-through
// bypass, a pending-write scoreboard, and a sequential clear engine that
// zeroes the array after reset or on request. The array has no reset of its
// own so it can map onto LUTRAM; the clear engine supplies the zero values.
//
// Port timing: writes, scoreboard sets and clear requests are sampled on the
// rising clock edge and only while init_busy is 0; anything presented while
// init_busy is 1 is dropped, not held. Reads are purely combinational.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 3,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr_req,
    output logic                init_busy,
    input  logic                we0,
    input  logic [AW-1:0]       waddr0,
    input  logic [XLEN-1:0]     wdata0,
    input  logic                we1,
    input  logic [AW-1:0]       waddr1,
    input  logic [XLEN-1:0]     wdata1,
    input  logic [NRD-1:0]      re,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rd_pend,
    input  logic                sb_set,
    input  logic [AW-1:0]       sb_addr
);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [AW-1:0]     clr_cnt;
    logic [AW-1:0]     clr_cnt_nxt;
    logic [NREGS-1:0]  pend;
    logic [NREGS-1:0]  pend_nxt;
    logic [XLEN-1:0]   mem [NREGS];
    logic [AW-1:0]     ra [NRD];

    logic ready;
    logic wr0_ok;
    logic wr1_ok;
    logic sb_ok;

    // Address is backed by a physical register (only matters when NREGS is not a power of 2).
    function automatic logic in_range(input logic [AW-1:0] a);
        return (32'(a) < NREGS);
    endfunction

    // Address is the hardwired zero register.
    function automatic logic is_zero(input logic [AW-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    assign ready     = (state == READY);
    assign init_busy = (state == CLEAR);

    // Accepted operations: only in READY, only to real, writable registers.
    assign wr0_ok = ready && we0 && in_range(waddr0) && !is_zero(waddr0);
    assign wr1_ok = ready && we1 && in_range(waddr1) && !is_zero(waddr1);
    assign sb_ok  = ready && sb_set && in_range(sb_addr) && !is_zero(sb_addr);

    // State and clear-counter registers; reset restarts the clear from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            pend    <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            pend    <= pend_nxt;
        end
    end

    // Next-state logic: CLEAR walks every register once, READY waits for clr_req.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            CLEAR: begin
                if (clr_cnt == AW'(NREGS - 1)) begin
                    state_nxt   = READY;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            READY: begin
                if (clr_req) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // Scoreboard update: writes clear, issue sets (set applied last so it wins).
    always_comb begin
        pend_nxt = pend;
        if (ready) begin
            if (clr_req) begin
                pend_nxt = '0;
            end else begin
                if (wr0_ok) pend_nxt[waddr0] = 1'b0;
                if (wr1_ok) pend_nxt[waddr1] = 1'b0;
                if (sb_ok)  pend_nxt[sb_addr] = 1'b1;
            end
        end
    end

    // Array writes: clear engine in CLEAR, ports in READY with port 1 written last so it wins.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (wr0_ok) mem[waddr0] <= wdata0;
            if (wr1_ok) mem[waddr1] <= wdata1;
        end
    end

    // Unpack the read address bus into one address per port.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            ra[i] = raddr[i*AW +: AW];
        end
    end

    // Read ports: zero when idle/clearing/zero-reg/out-of-range, else bypass then array.
    always_comb begin
        rdata   = '0;
        rd_pend = '0;
        for (int i = 0; i < NRD; i++) begin
            if (ready && re[i] && in_range(ra[i]) && !is_zero(ra[i])) begin
                if (BYPASS && wr1_ok && (waddr1 == ra[i])) begin
                    rdata[i*XLEN +: XLEN] = wdata1;
                end else if (BYPASS && wr0_ok && (waddr0 == ra[i])) begin
                    rdata[i*XLEN +: XLEN] = wdata0;
                end else begin
                    rdata[i*XLEN +: XLEN] = mem[ra[i]];
                end
                rd_pend[i] = pend[ra[i]] &&
                             !(BYPASS && ((wr1_ok && (waddr1 == ra[i])) ||
                                          (wr0_ok && (waddr0 == ra[i]))));
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp. The stimulus process drives inputs just after
// each rising edge and queues the values the outputs must show in that cycle;
// a monitor on the falling edge pops the queue and compares.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 3;
    localparam int AW    = 5;

    // Expectation kinds: 0..NRD-1 rdata of that port, 10+p rd_pend of port p, 20 init_busy.
    localparam int K_PEND = 10;
    localparam int K_BUSY = 20;

    logic                clk;
    logic                rst_n;
    logic                clr_req;
    logic                init_busy;
    logic                we0;
    logic [AW-1:0]       waddr0;
    logic [XLEN-1:0]     wdata0;
    logic                we1;
    logic [AW-1:0]       waddr1;
    logic [XLEN-1:0]     wdata1;
    logic [NRD-1:0]      re;
    logic [NRD*AW-1:0]   raddr;
    logic [NRD*XLEN-1:0] rdata;
    logic [NRD-1:0]      rd_pend;
    logic                sb_set;
    logic [AW-1:0]       sb_addr;

    logic [XLEN-1:0] exp_q[$];
    int              kind_q[$];
    string           name_q[$];

    int checks;
    int failures;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .init_busy(init_busy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .re(re), .raddr(raddr), .rdata(rdata), .rd_pend(rd_pend),
        .sb_set(sb_set), .sb_addr(sb_addr)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        sb_set = 1'b0; sb_addr = '0;
        clr_req = 1'b0;
        re = '0; raddr = '0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        re[p] = 1'b1;
        raddr[p*AW +: AW] = a;
    endtask

    task automatic wr0(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        we0 = 1'b1; waddr0 = a; wdata0 = d;
    endtask

    task automatic wr1(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        we1 = 1'b1; waddr1 = a; wdata1 = d;
    endtask

    task automatic expect_out(input int kind, input logic [XLEN-1:0] v, input string n);
        kind_q.push_back(kind);
        exp_q.push_back(v);
        name_q.push_back(n);
    endtask

    // ---------------- scoreboard monitor ----------------
    int              mon_kind;
    logic [XLEN-1:0] mon_exp;
    logic [XLEN-1:0] mon_act;
    string           mon_name;

    // Compare every expectation queued for this cycle against the live outputs.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_kind = kind_q.pop_front();
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            if (mon_kind < K_PEND)
                mon_act = rdata[mon_kind*XLEN +: XLEN];
            else if (mon_kind < K_BUSY)
                mon_act = {31'b0, rd_pend[mon_kind-K_PEND]};
            else
                mon_act = {31'b0, init_busy};
            checks++;
            if (mon_act !== mon_exp) begin
                failures++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", mon_name, mon_act, mon_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        checks   = 0;
        failures = 0;
        idle();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // Reset held: engine busy, reads forced to zero.
        step();
        rd(0, 5'd5);
        expect_out(K_BUSY, 32'd1, "reset_busy");
        expect_out(0, 32'd0, "reset_rdata");
        expect_out(K_PEND + 0, 32'd0, "reset_rd_pend");
        step();

        // Release: busy for exactly 32 edges.
        rst_n = 1'b1;
        for (int k = 0; k < NREGS; k++) begin
            expect_out(K_BUSY, 32'd1, "init_busy_during_clear");
            step();
        end
        expect_out(K_BUSY, 32'd0, "init_busy_done");
        expect_out(0, 32'd0, "x5_after_init");
        step();

        // Bypass of a same-cycle write, then the stored value.
        idle();
        wr0(5'd5, 32'hDEADBEEF);
        rd(0, 5'd5);
        rd(1, 5'd5);
        re[1] = 1'b0;
        expect_out(0, 32'hDEADBEEF, "x5_bypass");
        expect_out(1, 32'd0, "re_low_reads_zero");
        step();
        idle();
        rd(0, 5'd5);
        expect_out(0, 32'hDEADBEEF, "x5_stored");
        step();

        // Both ports write x7: port 1 wins, both in bypass and in storage.
        idle();
        wr0(5'd7, 32'h11);
        wr1(5'd7, 32'h22);
        rd(1, 5'd7);
        rd(2, 5'd5);
        expect_out(1, 32'h22, "x7_bypass_port1_wins");
        expect_out(2, 32'hDEADBEEF, "x5_on_port2");
        step();
        idle();
        rd(1, 5'd7);
        expect_out(1, 32'h22, "x7_stored_port1_wins");
        step();

        // Register 0 is hardwired: write dropped, never pending.
        idle();
        wr1(5'd0, 32'hFFFFFFFF);
        sb_set = 1'b1; sb_addr = 5'd0;
        rd(2, 5'd0);
        expect_out(2, 32'd0, "x0_same_cycle");
        expect_out(K_PEND + 2, 32'd0, "x0_pend_same_cycle");
        step();
        idle();
        rd(2, 5'd0);
        expect_out(2, 32'd0, "x0_after");
        expect_out(K_PEND + 2, 32'd0, "x0_pend_after");
        step();

        // Scoreboard set / clear / set-wins.
        idle();
        sb_set = 1'b1; sb_addr = 5'd9;
        rd(0, 5'd9);
        expect_out(K_PEND + 0, 32'd0, "x9_pend_before_set");
        step();
        idle();
        rd(0, 5'd9);
        expect_out(K_PEND + 0, 32'd1, "x9_pend_set");
        expect_out(0, 32'd0, "x9_cleared_value");
        step();
        idle();
        wr0(5'd9, 32'h99);
        rd(0, 5'd9);
        expect_out(K_PEND + 0, 32'd0, "x9_pend_masked_by_write");
        expect_out(0, 32'h99, "x9_bypass");
        step();
        idle();
        rd(0, 5'd9);
        expect_out(K_PEND + 0, 32'd0, "x9_pend_cleared");
        step();
        idle();
        sb_set = 1'b1; sb_addr = 5'd9;
        wr1(5'd9, 32'hAA);
        rd(0, 5'd9);
        expect_out(K_PEND + 0, 32'd0, "x9_pend_masked_set_and_write");
        expect_out(0, 32'hAA, "x9_bypass_port1");
        step();
        idle();
        rd(0, 5'd9);
        expect_out(K_PEND + 0, 32'd1, "x9_pend_set_wins");
        expect_out(0, 32'hAA, "x9_stored_aa");
        step();

        // Clear request: everything zeroed, writes during clear dropped.
        idle();
        wr0(5'd3, 32'd5);
        step();
        idle();
        rd(0, 5'd3);
        expect_out(0, 32'd5, "x3_before_clear");
        clr_req = 1'b1;
        step();
        idle();
        for (int k = 0; k < NREGS; k++) begin
            if (k == 0) begin
                wr0(5'd3, 32'd7);
                sb_set = 1'b1; sb_addr = 5'd3;
                rd(0, 5'd3);
                rd(1, 5'd9);
                expect_out(0, 32'd0, "rdata_zero_in_clear");
                expect_out(K_PEND + 1, 32'd0, "rd_pend_zero_in_clear");
            end
            expect_out(K_BUSY, 32'd1, "clr_busy_during_clear");
            step();
            idle();
        end
        rd(0, 5'd3);
        rd(1, 5'd9);
        rd(2, 5'd3);
        expect_out(K_BUSY, 32'd0, "clr_busy_done");
        expect_out(0, 32'd0, "x3_zero_after_clear");
        expect_out(K_PEND + 1, 32'd0, "x9_pend_zero_after_clear");
        expect_out(K_PEND + 2, 32'd0, "x3_not_pending_after_clear");
        step();
        idle();
        rd(0, 5'd7);
        expect_out(0, 32'd0, "x7_zero_after_clear");
        step();

        // Every queued expectation must have been consumed by the monitor.
        step();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
